// File: rtl/gray_step_monitor_if.sv
// Gray monitor bus: counter-side inputs and decoded/status outputs.
// The master drives samples, the slave is the monitor itself.
interface gray_step_monitor_if #(
    parameter int CBITS = 17,
    parameter int ECW   = 8
);
    logic [CBITS-1:0] gray_in;
    logic             gray_vld;
    logic             clr;
    logic [CBITS-1:0] bin_out;
    logic             bin_vld;
    logic             wrap;
    logic             step_err;
    logic [ECW-1:0]   err_cnt;
    logic             locked;
    logic             fault;

    modport master (
        output gray_in, gray_vld, clr,
        input  bin_out, bin_vld, wrap, step_err,
        input  err_cnt, locked, fault
    );

    modport slave (
        input  gray_in, gray_vld, clr,
        output bin_out, bin_vld, wrap, step_err,
        output err_cnt, locked, fault
    );
endinterface

// File: rtl/gray_step_monitor.sv
// Registers a Gray count, decodes it to binary and checks for +1 steps.
// Repeated consecutive bad steps latch a fault until clr or reset.
module gray_step_monitor #(
    parameter int CBITS     = 17,
    parameter int ERR_LIMIT = 3,
    parameter int ECW       = 8
) (
    input logic clk,
    input logic rst_n,
    gray_step_monitor_if.slave bus
);
    localparam int CW = $clog2(ERR_LIMIT + 1);

    typedef enum logic [1:0] {
        ACQ   = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t           state;
    logic             s1_vld;
    logic [CBITS-1:0] s1_gray;
    logic             s2_vld;
    logic [CBITS-1:0] s2_bin;
    logic [CBITS-1:0] prev;
    logic [CW-1:0]    consec;
    logic [CBITS-1:0] dec;
    logic [CBITS-1:0] nxt;
    logic [CW-1:0]    consec_inc;
    logic             is_step;
    logic             is_hold;

    logic [CBITS-1:0] bin_out;
    logic             bin_vld;
    logic             wrap;
    logic             step_err;
    logic [ECW-1:0]   err_cnt;

    // Each binary bit is the parity of the Gray bits at and above it.
    always_comb begin
        dec = '0;
        for (int i = 0; i < CBITS; i++) begin
            dec[i] = ^(s1_gray >> i);
        end
    end

    assign nxt        = prev + CBITS'(1);
    assign is_step    = (s2_bin == nxt);
    assign is_hold    = (s2_bin == prev);
    assign consec_inc = consec + CW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld   <= 1'b0;
            s1_gray  <= '0;
            s2_vld   <= 1'b0;
            s2_bin   <= '0;
            prev     <= '0;
            consec   <= '0;
            state    <= ACQ;
            bin_out  <= '0;
            bin_vld  <= 1'b0;
            wrap     <= 1'b0;
            step_err <= 1'b0;
            err_cnt  <= '0;
        end else if (bus.clr) begin
            s1_vld   <= 1'b0;
            s2_vld   <= 1'b0;
            bin_vld  <= 1'b0;
            wrap     <= 1'b0;
            step_err <= 1'b0;
            consec   <= '0;
            err_cnt  <= '0;
            state    <= ACQ;
        end else begin
            s1_vld   <= bus.gray_vld;
            s1_gray  <= bus.gray_in;
            s2_vld   <= s1_vld;
            s2_bin   <= dec;
            bin_vld  <= s2_vld;
            wrap     <= 1'b0;
            step_err <= 1'b0;
            if (s2_vld) begin
                bin_out <= s2_bin;
                prev    <= s2_bin;
                unique case (state)
                    ACQ: state <= TRACK;
                    TRACK: begin
                        if (is_step) begin
                            consec <= '0;
                            wrap   <= (prev == '1);
                        end else if (!is_hold) begin
                            step_err <= 1'b1;
                            consec   <= consec_inc;
                            if (err_cnt != '1)
                                err_cnt <= err_cnt + ECW'(1);
                            if (consec_inc == CW'(ERR_LIMIT))
                                state <= FAULT;
                        end
                    end
                    FAULT: state <= FAULT;
                    default: state <= ACQ;
                endcase
            end
        end
    end

    assign bus.bin_out  = bin_out;
    assign bus.bin_vld  = bin_vld;
    assign bus.wrap     = wrap;
    assign bus.step_err = step_err;
    assign bus.err_cnt  = err_cnt;
    assign bus.locked   = (state == TRACK);
    assign bus.fault    = (state == FAULT);
endmodule

// File: tb/tb_gray_step_monitor.sv
// Bench for gray_step_monitor: directed scenarios plus random traffic
// checked every cycle against a sample-queue reference model.
module tb_gray_step_monitor;
    localparam int CBITS     = 17;
    localparam int ERR_LIMIT = 3;
    localparam int ECW       = 8;
    localparam int M         = 1 << CBITS;
    localparam int ESAT      = (1 << ECW) - 1;

    logic clk = 1'b0;
    logic rst_n;

    gray_step_monitor_if #(.CBITS(CBITS), .ECW(ECW)) bus ();

    gray_step_monitor #(
        .CBITS(CBITS),
        .ERR_LIMIT(ERR_LIMIT),
        .ECW(ECW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    int vld_seen = 0;

    // Reference model: 0=acquiring, 1=tracking, 2=faulted
    int m_mode, m_prev, m_consec, m_err;
    int e_bin, e_vld, e_wrap, e_serr;
    int q_bin[$];
    int q_due[$];

    function automatic int g(int b);
        return (b ^ (b >> 1)) & (M - 1);
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h cyc=%0d",
                    tag, obs, exp, cyc);
    endtask

    task automatic model_reset();
        m_mode = 0; m_prev = 0; m_consec = 0; m_err = 0;
        e_bin = 0; e_vld = 0; e_wrap = 0; e_serr = 0;
        q_bin.delete();
        q_due.delete();
    endtask

    task automatic process(int b);
        e_vld = 1;
        e_bin = b;
        if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (b == (m_prev + 1) % M) begin
                m_consec = 0;
                e_wrap = (m_prev == M - 1) ? 1 : 0;
            end else if (b != m_prev) begin
                e_serr = 1;
                if (m_err < ESAT) m_err++;
                m_consec++;
                if (m_consec >= ERR_LIMIT) m_mode = 2;
            end
        end
        m_prev = b;
    endtask

    task automatic check_all();
        chk("bin_vld",  32'(bus.bin_vld),  32'(e_vld));
        chk("bin_out",  32'(bus.bin_out),  32'(e_bin));
        chk("wrap",     32'(bus.wrap),     32'(e_wrap));
        chk("step_err", 32'(bus.step_err), 32'(e_serr));
        chk("err_cnt",  32'(bus.err_cnt),  32'(m_err));
        chk("locked",   32'(bus.locked),   32'(m_mode == 1));
        chk("fault",    32'(bus.fault),    32'(m_mode == 2));
    endtask

    task automatic step(bit v, int b, bit c);
        bus.gray_vld = v;
        bus.gray_in  = CBITS'(g(b));
        bus.clr      = c;
        @(posedge clk);
        cyc++;
        e_vld = 0; e_wrap = 0; e_serr = 0;
        if (!rst_n) begin
            model_reset();
        end else if (c) begin
            q_bin.delete();
            q_due.delete();
            m_mode = 0; m_err = 0; m_consec = 0;
        end else begin
            if (q_due.size() > 0 && q_due[0] == cyc) begin
                process(q_bin[0]);
                void'(q_bin.pop_front());
                void'(q_due.pop_front());
            end
            if (v) begin
                q_bin.push_back(b);
                q_due.push_back(cyc + 2);
            end
        end
        #1;
        check_all();
        if (bus.bin_vld === 1'b1) vld_seen++;
    endtask

    task automatic send(int b);
        step(1'b1, b % M, 1'b0);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0);
    endtask

    task automatic clear();
        step(1'b0, 0, 1'b1);
    endtask

    initial begin
        int last;
        int b;
        rst_n = 1'b0;
        bus.gray_in = '0;
        bus.gray_vld = 1'b0;
        bus.clr = 1'b0;
        model_reset();

        // T1: reset state, then 0..4 as Gray 0,1,3,2,6
        idle(2);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) send(i);
        idle(2);
        chk("t1_bin", 32'(bus.bin_out), 32'd4);
        chk("t1_locked", 32'(bus.locked), 32'd1);

        // T2: all-ones to zero wraps cleanly
        clear();
        send(M - 1);
        send(0);
        idle(2);
        chk("t2_bin", 32'(bus.bin_out), 32'd0);
        chk("t2_err", 32'(bus.err_cnt), 32'd0);

        // T3: one bad step then recovery
        clear();
        send(5); send(7); send(8);
        idle(2);
        chk("t3_err", 32'(bus.err_cnt), 32'd1);
        chk("t3_locked", 32'(bus.locked), 32'd1);

        // T4: three consecutive bad steps latch a fault
        clear();
        send(1); send(4); send(9); send(20);
        idle(2);
        chk("t4_fault", 32'(bus.fault), 32'd1);
        send(21); send(30);
        idle(2);
        chk("t4_err", 32'(bus.err_cnt), 32'd3);
        clear();
        chk("t4_clr_err", 32'(bus.err_cnt), 32'd0);
        send(50);
        idle(2);
        chk("t4_relock", 32'(bus.locked), 32'd1);

        // T5: holds and gaps are not errors
        clear();
        vld_seen = 0;
        send(10); send(10); send(10);
        idle(4);
        send(11);
        idle(2);
        chk("t5_pulses", 32'(vld_seen), 32'd4);
        chk("t5_err", 32'(bus.err_cnt), 32'd0);

        // T6: asynchronous reset between edges mid-stream
        clear();
        send(100); send(105); send(106); send(107);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_vld", 32'(bus.bin_vld), 32'd0);
        chk("t6_locked", 32'(bus.locked), 32'd0);
        chk("t6_err", 32'(bus.err_cnt), 32'd0);
        chk("t6_bin", 32'(bus.bin_out), 32'd0);
        model_reset();
        idle(1);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) send(i);
        idle(2);

        // Error counter saturation with non-consecutive errors
        clear();
        b = 0;
        send(b);
        for (int i = 0; i < 260; i++) begin
            send(b + 7);
            send(b + 8);
            b = b + 8;
        end
        idle(2);
        chk("sat_err", 32'(bus.err_cnt), 32'(ESAT));
        chk("sat_locked", 32'(bus.locked), 32'd1);

        // Random traffic
        last = 0;
        for (int i = 0; i < 600; i++) begin
            int r;
            int k;
            r = $urandom_range(0, 99);
            if (r < 4) begin
                clear();
            end else if (r < 30) begin
                idle(1);
            end else begin
                k = $urandom_range(0, 9);
                if (k < 6) b = (last + 1) % M;
                else if (k < 8) b = last;
                else b = $urandom_range(0, M - 1);
                send(b);
                last = b;
            end
        end
        idle(3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
